rr_prio_encoder: RTL and testbench
==================================

# rr_prio_encoder

Parametrised, registered N-to-log2(N) priority encoder that succeeds the team's fixed 8-to-3 encoder. It supports two run-time modes: fixed priority, where the highest index wins, and round-robin, with a rotating pointer. It also flags multi-hot inputs and holds its result behind a valid/ready output stage. It sits between request sources and a downstream consumer that accepts one encoded index per handshake.

## Interface
- `N`, default 8: number of request lines; N >= 2, not necessarily a power of two.
- `W`, default `$clog2(N)`: index width; derived, do not override.
- `clk`, in, 1: single clock; all state is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req`, in, N: request vector, sampled on load cycles.
- `mode`, in, 1: 0 = fixed priority (highest index wins), 1 = round-robin.
- `out_ready`, in, 1: consumer accepts `y` when `out_valid & out_ready`.
- `y`, out, W: encoded winning index.
- `out_valid`, out, 1: `y` and `multi` are valid.
- `multi`, out, 1: more than one `req` bit was set when `y` was loaded.

## Operation
- Load condition: `load = !out_valid | out_ready`. With no load, `y`, `multi`, `out_valid` and the pointer hold.
- On load with `req != 0`:
  - `out_valid <= 1`.
  - `y <= winner`.
  - `multi <= (popcount(req) > 1)`.
- On load with `req == 0`: `out_valid <= 0`, `y <= 0`, `multi <= 0`.
- Fixed mode: winner is the highest set index, matching the legacy 8-to-3 behaviour on one-hot inputs. The pointer `ptr` is not modified.
- Round-robin mode:
  - Search order is `ptr, ptr+1, …, N-1, 0, …, ptr-1`; the first set bit wins.
  - On a load with nonzero `req`, `ptr <= (winner == N-1) ? 0 : winner+1`.
  - Wrap is explicit and required for non-power-of-two N.
- `ptr` is W bits, resets to 0 and holds its value across mode changes.
- `mode` is sampled on the load cycle only. A mode change while `out_valid=1` and stalled does not alter the held `y`.
- `req` bits at index >= N do not exist; no out-of-range `y` is ever produced.

## Timing
- Reset values: `y=0`, `out_valid=0`, `multi=0`, `ptr=0`. These are asserted asynchronously the moment `rst` rises, including mid-transfer; the held result is discarded.
- After `rst` falls, the first load occurs on the first rising edge.
- Latency is 1 cycle: `req` at edge k appears on `y`/`out_valid` after edge k when load is true.
- Throughput is one index per cycle while `out_ready=1`.
- Backpressure: with `out_valid=1` and `out_ready=0`, the outputs and `ptr` are frozen and `req` changes are ignored.
- The same-cycle accept-and-reload path is combinational through `out_ready` only; `req` never propagates combinationally to the outputs.

## Structure
- Package `enc_pkg`: `MODE_FIXED = 1'b0` and `MODE_RR = 1'b1` constants, plus a function that computes the wrapped increment `ptr_next(idx, N)`.
- Sub-module `prio_pick #(N)`: purely combinational. It takes `req`, `ptr` and `mode` and returns `winner[W-1:0]`, `any` and `multi`.
  - Round-robin search uses the double-width masked-vector method.
  - The top level holds only the output register, the pointer register and the load logic.

## Test plan
Cases use N=8 unless stated otherwise.
- **One-hot sweep, fixed mode, `out_ready=1`:** drive `req` = 0x02, 0x04, …, 0x80 -> `y` = 1, 2, …, 7, each one cycle later, with `multi=0`; then `req=0` -> `out_valid=0`, `y=0`.
- **Multi-hot, fixed mode:** `req=8'b1001_0100` -> `y=7`, `multi=1`; then `req=8'b0000_0001` -> `y=0`, `multi=0`.
- **Round-robin rotation:** from reset, `mode=1`, `req=8'b1000_0101` held, `out_ready=1` -> `y` sequence 0, 2, 7, 0, 2; `ptr` wraps from 7 to 0.
- **Backpressure:**
  - With `y=2` valid, `out_ready=0` for 3 cycles while `req` changes to 0x10 -> `y` stays 2 and `ptr` stays 3.
  - Raise `out_ready` -> the next load selects from current `req`, giving `y=4`.
- **Asynchronous reset mid-operation:** assert `rst` between edges while `out_valid=1` and `ptr=5` -> `out_valid=0`, `y=0` and `multi=0` immediately. After release, round-robin with `req=0xFF` gives `y=0`.
- **Non-power-of-two, `N=5` (`W=3`), round-robin:** `req=5'b10001` -> `y` alternates 0, 4, 0, 4; `y` never exceeds 4.

Source files
------------

// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - mode constants and wrapped pointer increment for rr_prio_encoder
package enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Next round-robin start index; wraps explicitly so non-power-of-two N works.
  function automatic int ptr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_prio_encoder_prio_pick.sv
// rtl/rr_prio_encoder_prio_pick.sv - combinational winner selection, fixed or round-robin
module prio_pick
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic [W-1:0] winner,
  output logic         any,
  output logic         multi
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic [W-1:0]   fix_w;
  logic [W-1:0]   rr_w;

  assign dbl   = {req, req};
  assign any   = |req;
  assign multi = (req & (req - 1'b1)) != '0;

  always_comb begin
    fix_w = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) fix_w = W'(i);
    end
  end

  // Bits below ptr are masked off; the upper copy supplies the wrapped tail.
  always_comb begin
    masked = '0;
    rr_w   = '0;
    for (int i = 0; i < 2 * N; i++) begin
      masked[i] = dbl[i] && (i >= int'(ptr));
    end
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (masked[i]) rr_w = (i >= N) ? W'(i - N) : W'(i);
    end
  end

  assign winner = (mode == MODE_RR) ? rr_w : fix_w;

endmodule

// File: rtl/rr_prio_encoder.sv
// rtl/rr_prio_encoder.sv - registered N-to-log2(N) priority encoder with valid/ready output
module rr_prio_encoder
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         out_valid,
  output logic         multi
);

  logic [W-1:0] ptr;
  logic [W-1:0] winner;
  logic         any;
  logic         multi_c;
  logic         load;

  prio_pick #(.N(N)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .mode   (mode),
    .winner (winner),
    .any    (any),
    .multi  (multi_c)
  );

  assign load = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y         <= '0;
      out_valid <= 1'b0;
      multi     <= 1'b0;
      ptr       <= '0;
    end else if (load) begin
      if (any) begin
        out_valid <= 1'b1;
        y         <= winner;
        multi     <= multi_c;
        if (mode == MODE_RR) ptr <= W'(ptr_next(int'(winner), N));
      end else begin
        out_valid <= 1'b0;
        y         <= '0;
        multi     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_prio_encoder.sv
// tb/tb_rr_prio_encoder.sv - randomized and directed checks of rr_prio_encoder (N=8 and N=5)
module tb_rr_prio_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req8 = '0;
  logic       mode8 = 1'b0;
  logic       rdy8 = 1'b1;
  logic [2:0] y8;
  logic       v8;
  logic       multi8;
  logic [4:0] req5 = '0;
  logic       mode5 = 1'b0;
  logic       rdy5 = 1'b1;
  logic [2:0] y5;
  logic       v5;
  logic       multi5;

  int n_checks = 0;
  int n_errors = 0;

  int m_v[2];
  int m_y[2];
  int m_multi[2];
  int m_ptr[2];

  rr_prio_encoder #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .req(req8), .mode(mode8), .out_ready(rdy8),
    .y(y8), .out_valid(v8), .multi(multi8)
  );

  rr_prio_encoder #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .req(req5), .mode(mode5), .out_ready(rdy5),
    .y(y5), .out_valid(v5), .multi(multi5)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 0; m_y[k] = 0; m_multi[k] = 0; m_ptr[k] = 0;
    end
  endfunction

  // Reference: count set bits, then scan the request indices in the order the mode defines.
  function automatic void model_step(input int k, input int n, input int r, input int md, input int rd);
    int cnt;
    int win;
    int idx;
    if (m_v[k] != 0 && rd == 0) return;
    cnt = 0;
    win = -1;
    for (int i = 0; i < n; i++) if (r[i]) cnt++;
    if (cnt == 0) begin
      m_v[k] = 0; m_y[k] = 0; m_multi[k] = 0;
      return;
    end
    if (md == 0) begin
      for (int i = 0; i < n; i++) if (r[i]) win = i;
    end else begin
      for (int off = 0; off < n; off++) begin
        idx = (m_ptr[k] + off) % n;
        if (r[idx] && win < 0) win = idx;
      end
      m_ptr[k] = (win + 1) % n;
    end
    m_v[k] = 1;
    m_y[k] = win;
    m_multi[k] = (cnt > 1) ? 1 : 0;
  endfunction

  task automatic compare_model();
    check("n8_valid", int'(v8), m_v[0]);
    check("n8_y", int'(y8), m_y[0]);
    check("n8_multi", int'(multi8), m_multi[0]);
    check("n5_valid", int'(v5), m_v[1]);
    check("n5_y", int'(y5), m_y[1]);
    check("n5_multi", int'(multi5), m_multi[1]);
    check("n5_y_range", int'(y5 <= 3'd4), 1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, 8, int'(req8), int'(mode8), int'(rdy8));
    model_step(1, 5, int'(req5), int'(mode5), int'(rdy5));
    #1;
    compare_model();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_valid", int'(v8), 0);
    check("rst_y", int'(y8), 0);
    check("rst_multi", int'(multi8), 0);
    check("rst_valid5", int'(v5), 0);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    check("reset_valid", int'(v8), 0);
    check("reset_y", int'(y8), 0);
    check("reset_multi", int'(multi8), 0);
    @(posedge clk);
    #1;
    compare_model();
    rst = 1'b0;

    mode5 = 1'b1; req5 = 5'b10001; rdy5 = 1'b1;

    // One-hot sweep, fixed mode
    mode8 = 1'b0; rdy8 = 1'b1;
    for (int i = 1; i < 8; i++) begin
      req8 = 8'(1 << i);
      tick();
      check("sweep_y", int'(y8), i);
      check("sweep_multi", int'(multi8), 0);
    end
    req8 = 8'h00;
    tick();
    check("zero_valid", int'(v8), 0);
    check("zero_y", int'(y8), 0);

    // Multi-hot, fixed mode
    req8 = 8'b1001_0100;
    tick();
    check("mh_y", int'(y8), 7);
    check("mh_multi", int'(multi8), 1);
    req8 = 8'b0000_0001;
    tick();
    check("oh0_y", int'(y8), 0);
    check("oh0_multi", int'(multi8), 0);

    // Round-robin rotation from reset
    async_reset();
    mode8 = 1'b1; req8 = 8'b1000_0101;
    begin
      int seq[5] = '{0, 2, 7, 0, 2};
      for (int i = 0; i < 5; i++) begin
        tick();
        check("rr_seq", int'(y8), seq[i]);
      end
    end

    // Backpressure: y=2 held, ptr=3
    rdy8 = 1'b0; req8 = 8'h10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_y", int'(y8), 2);
      check("bp_hold_valid", int'(v8), 1);
    end
    rdy8 = 1'b1;
    tick();
    check("bp_release_y", int'(y8), 4);

    // Async reset while valid with ptr=5
    async_reset();
    req8 = 8'hFF; mode8 = 1'b1;
    tick();
    check("post_rst_y", int'(y8), 0);

    // Non-power-of-two N=5 round-robin
    async_reset();
    begin
      int seq5[4] = '{0, 4, 0, 4};
      for (int i = 0; i < 4; i++) begin
        tick();
        check("n5_seq", int'(y5), seq5[i]);
        check("n5_seq_multi", int'(multi5), 1);
      end
    end

    // Random traffic with occasional mid-cycle async resets
    for (int c = 0; c < 600; c++) begin
      req8  = 8'($urandom_range(0, 255));
      mode8 = 1'($urandom_range(0, 1));
      rdy8  = ($urandom_range(0, 3) != 0);
      req5  = 5'($urandom_range(0, 31));
      mode5 = 1'($urandom_range(0, 1));
      rdy5  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) async_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
